// File: rtl/rotary_addsub_pkg.sv
// Shared encodings for the rotary-entry add/sub block: entry phases, op-nibble
// bit positions and the operand nibble count.
package rotary_addsub_pkg;

  typedef enum logic [1:0] {
    PH_LOAD_A  = 2'd0,
    PH_LOAD_B  = 2'd1,
    PH_LOAD_OP = 2'd2,
    PH_SHOW    = 2'd3
  } phase_e;

  localparam int OP_SUB = 0;
  localparam int OP_SAT = 1;

  function automatic int nibs_of(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational ripple add/sub: subtract is A + ~B + 1, so sub_i doubles as carry-in.
module addsub_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             msb_carry_in_o
);

  logic [WIDTH:0] c;

  assign c[0] = sub_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    one_bit_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i] ^ sub_i),
      .c_i (c[i]),
      .s_o (sum_o[i]),
      .c_o (c[i+1])
    );
  end

  assign carry_o        = c[WIDTH];
  assign msb_carry_in_o = c[WIDTH-1];

endmodule

// File: rtl/one_bit_adder.sv
// Single full-adder cell used to build the ripple chain.
module one_bit_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/rotary_addsub_n.sv
// Rotary-entry WIDTH-bit adder/subtractor: A, B and an op nibble are entered one
// nibble per rotation step; the result is registered with carry and signed overflow.
module rotary_addsub_n
  import rotary_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_evt,
  input  logic [3:0]       nib_in,
  input  logic             clear,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             result_valid,
  output logic [1:0]       phase,
  output logic [1:0]       nib_idx
);

  localparam int         NIBS     = nibs_of(WIDTH);
  localparam logic [1:0] LAST_IDX = 2'(NIBS - 1);

  phase_e           phase_q;
  logic [1:0]       idx_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, ovf_q, valid_q, prev_evt_q;

  logic             step;
  logic [WIDTH-1:0] load_d;
  logic [4*NIBS-1:0] load_wide;
  logic [WIDTH-1:0] core_sum, sum_d;
  logic             core_carry, core_msb_cin, ovf_d;

  assign step = step_evt & ~prev_evt_q;

  // Merge nib_in into the operand being entered; bits past WIDTH fall off the top.
  always_comb begin
    load_wide = '0;
    load_wide[WIDTH-1:0] = (phase_q == PH_LOAD_A) ? a_q : b_q;
    for (int k = 0; k < NIBS; k++) begin
      if (idx_q == 2'(k)) load_wide[4*k +: 4] = nib_in;
    end
    load_d = load_wide[WIDTH-1:0];
  end

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a_i            (a_q),
    .b_i            (b_q),
    .sub_i          (nib_in[OP_SUB]),
    .sum_o          (core_sum),
    .carry_o        (core_carry),
    .msb_carry_in_o (core_msb_cin)
  );

  // Saturation direction follows A's sign; carry stays the unsaturated one.
  always_comb begin
    ovf_d = core_carry ^ core_msb_cin;
    sum_d = core_sum;
    if (nib_in[OP_SAT] && ovf_d) begin
      sum_d = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  // result_valid has no ready: it is high from the op step until the next step
  // out of SHOW (or clear/reset); sum/flags are meaningful only while it is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= PH_LOAD_A;
      idx_q      <= 2'd0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      prev_evt_q <= 1'b1;
    end else begin
      prev_evt_q <= step_evt;
      if (clear) begin
        phase_q <= PH_LOAD_A;
        idx_q   <= 2'd0;
        a_q     <= '0;
        b_q     <= '0;
        sum_q   <= '0;
        carry_q <= 1'b0;
        ovf_q   <= 1'b0;
        valid_q <= 1'b0;
      end else if (step) begin
        case (phase_q)
          PH_LOAD_A: begin
            a_q <= load_d;
            if (idx_q == LAST_IDX) begin
              idx_q   <= 2'd0;
              phase_q <= PH_LOAD_B;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
          PH_LOAD_B: begin
            b_q <= load_d;
            if (idx_q == LAST_IDX) begin
              idx_q   <= 2'd0;
              phase_q <= PH_LOAD_OP;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
          PH_LOAD_OP: begin
            sum_q   <= sum_d;
            carry_q <= core_carry;
            ovf_q   <= ovf_d;
            valid_q <= 1'b1;
            phase_q <= PH_SHOW;
          end
          PH_SHOW: begin
            valid_q <= 1'b0;
            idx_q   <= 2'd0;
            phase_q <= PH_LOAD_A;
          end
        endcase
      end
    end
  end

  assign sum          = sum_q;
  assign carry_out    = carry_q;
  assign overflow     = ovf_q;
  assign result_valid = valid_q;
  assign phase        = phase_q;
  assign nib_idx      = idx_q;

endmodule
